fadd_operand_issue: RTL and testbench

FADD_OPERAND_ISSUE -- requirements
Module: fadd_operand_issue

---
 rtl/fadd_operand_issue_pkg.sv | 35 +++
 rtl/fp_classify.sv | 27 ++
 rtl/fadd_operand_issue.sv | 125 ++++++++++++
 tb/tb_fadd_operand_issue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fadd_operand_issue_pkg.sv
// Shared single-precision definitions for the add/sub front end and datapath:
// field widths, class encodings and the operand-queue entry layout.
package fadd_operand_issue_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp_class_e;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } fp_fields_t;

  typedef struct packed {
    fp_fields_t x;
    fp_fields_t y;
    logic       sub;
    logic [1:0] rm;
    fp_class_e  cls_x;
    fp_class_e  cls_y;
  } issue_entry_t;

endpackage

// File: rtl/fp_classify.sv
// IEEE-754 single operand classifier: zero / subnormal / normal / inf / qNaN / sNaN.
module fp_classify
  import fadd_operand_issue_pkg::*;
(
  input  logic [FP_W-1:0] i_op,
  output logic [2:0]      o_cls
);

  // Sign never affects the class.
  logic             w_sign_unused;
  logic [EXP_W-1:0] w_e;
  logic [MAN_W-1:0] w_m;

  assign {w_sign_unused, w_e, w_m} = i_op;

  always_comb begin
    o_cls = CLS_NORM;
    if (w_e == '0) begin
      o_cls = (w_m == '0) ? CLS_ZERO : CLS_SUB;
    end else if (w_e == EXP_ONES) begin
      if (w_m == '0)            o_cls = CLS_INF;
      else if (w_m[MAN_W-1])    o_cls = CLS_QNAN;
      else                      o_cls = CLS_SNAN;
    end
  end

endmodule

// File: rtl/fadd_operand_issue.sv
// Operand issue queue for the FP add/sub pipeline: classifies at push, buffers
// DEPTH ops, presents the head on registered outputs, pops when the pipe advances.
module fadd_operand_issue
  import fadd_operand_issue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FP_W-1:0]          in_a,
  input  logic [FP_W-1:0]          in_b,
  input  logic                     in_sub,
  input  logic [1:0]               in_rm,
  input  logic                     pipe_stall,
  output logic                     enable,
  output logic                     out_valid,
  output logic                     Sx,
  output logic                     Sy,
  output logic [EXP_W-1:0]         Ex,
  output logic [EXP_W-1:0]         Ey,
  output logic [MAN_W-1:0]         Mx,
  output logic [MAN_W-1:0]         My,
  output logic                     sub,
  output logic [1:0]               roundMode,
  output logic [2:0]               cls_x,
  output logic [2:0]               cls_y,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [CNT_W-1:0]         issued_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FILL_DEPTH = FILL_W'(DEPTH);

  logic [1:0][FP_W-1:0] w_ops;
  logic [1:0][2:0]      w_cls;

  assign w_ops = {in_b, in_a};

  for (genvar g = 0; g < 2; g++) begin : g_cls
    fp_classify u_cls (
      .i_op  (w_ops[g]),
      .o_cls (w_cls[g])
    );
  end

  issue_entry_t                  w_wr_entry;
  issue_entry_t                  w_head_nxt;
  issue_entry_t [DEPTH-1:0]      r_mem;
  issue_entry_t                  r_head;
  logic         [PTR_W-1:0]      r_rd, r_wr, w_rd_nxt;
  logic         [FILL_W-1:0]     r_fill, w_fill_nxt;
  logic         [CNT_W-1:0]      r_cnt;
  logic                          r_out_valid, r_in_ready;
  logic                          w_push, w_pop;

  always_comb begin
    w_wr_entry       = '0;
    w_wr_entry.x     = fp_fields_t'(in_a);
    w_wr_entry.y     = fp_fields_t'(in_b);
    w_wr_entry.sub   = in_sub;
    w_wr_entry.rm    = in_rm;
    w_wr_entry.cls_x = fp_class_e'(w_cls[0]);
    w_wr_entry.cls_y = fp_class_e'(w_cls[1]);
  end

  assign w_push     = in_valid & r_in_ready;
  assign w_pop      = r_out_valid & ~pipe_stall;
  assign w_fill_nxt = r_fill + FILL_W'(w_push) - FILL_W'(w_pop);
  assign w_rd_nxt   = r_rd + PTR_W'(w_pop);

  // The head after this edge is either the incoming op (queue drains to it),
  // the next stored entry, or unchanged when the queue goes empty.
  always_comb begin
    w_head_nxt = r_head;
    if (w_fill_nxt != '0) begin
      if (r_fill == FILL_W'(w_pop)) w_head_nxt = w_wr_entry;
      else                          w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem       <= '0;
      r_head      <= '0;
      r_rd        <= '0;
      r_wr        <= '0;
      r_fill      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_wr_entry;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) r_cnt <= r_cnt + CNT_W'(1);
      r_rd        <= w_rd_nxt;
      r_fill      <= w_fill_nxt;
      r_head      <= w_head_nxt;
      r_out_valid <= (w_fill_nxt != '0);
      r_in_ready  <= (w_fill_nxt < FILL_DEPTH);
    end
  end

  assign enable     = ~pipe_stall;
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign fill       = r_fill;
  assign issued_cnt = r_cnt;
  assign Sx         = r_head.x.s;
  assign Ex         = r_head.x.e;
  assign Mx         = r_head.x.m;
  assign Sy         = r_head.y.s;
  assign Ey         = r_head.y.e;
  assign My         = r_head.y.m;
  assign sub        = r_head.sub;
  assign roundMode  = r_head.rm;
  assign cls_x      = r_head.cls_x;
  assign cls_y      = r_head.cls_y;

endmodule

// File: tb/tb_fadd_operand_issue.sv
// Directed bench for fadd_operand_issue: vector table plus backpressure, streaming,
// counter wrap (CNT_W=4 instance) and asynchronous reset sequences.
module tb_fadd_operand_issue;

  logic        clk, rst, in_valid, in_sub, pipe_stall;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_rm;

  logic        in_ready, enable, out_valid, Sx, Sy, sub;
  logic [7:0]  Ex, Ey;
  logic [22:0] Mx, My;
  logic [1:0]  roundMode, fill;
  logic [2:0]  cls_x, cls_y;
  logic [15:0] issued_cnt;

  logic        in_ready4, enable4, out_valid4, Sx4, Sy4, sub4;
  logic [7:0]  Ex4, Ey4;
  logic [22:0] Mx4, My4;
  logic [1:0]  roundMode4, fill4;
  logic [2:0]  cls_x4, cls_y4;
  logic [3:0]  issued_cnt4;

  int n_chk = 0;
  int n_fail = 0;

  fadd_operand_issue #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_rm(in_rm),
    .pipe_stall(pipe_stall), .enable(enable), .out_valid(out_valid),
    .Sx(Sx), .Sy(Sy), .Ex(Ex), .Ey(Ey), .Mx(Mx), .My(My),
    .sub(sub), .roundMode(roundMode), .cls_x(cls_x), .cls_y(cls_y),
    .fill(fill), .issued_cnt(issued_cnt)
  );

  fadd_operand_issue #(.DEPTH(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_rm(in_rm),
    .pipe_stall(pipe_stall), .enable(enable4), .out_valid(out_valid4),
    .Sx(Sx4), .Sy(Sy4), .Ex(Ex4), .Ey(Ey4), .Mx(Mx4), .My(My4),
    .sub(sub4), .roundMode(roundMode4), .cls_x(cls_x4), .cls_y(cls_y4),
    .fill(fill4), .issued_cnt(issued_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [1:0]  rm;
    logic [2:0]  cx;
    logic [2:0]  cy;
  } vec_t;

  vec_t vecs[7];

  logic [73:0] obs, obs4;
  assign obs  = {out_valid,  Sx,  Ex,  Mx,  Sy,  Ey,  My,  sub,  roundMode,  cls_x,  cls_y};
  assign obs4 = {out_valid4, Sx4, Ex4, Mx4, Sy4, Ey4, My4, sub4, roundMode4, cls_x4, cls_y4};

  function automatic logic [73:0] exp_obs(input logic v, input vec_t t);
    return {v, t.a, t.b, t.sub, t.rm, t.cx, t.cy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_rm = '0;
    pipe_stall = 1'b0;

    vecs[0] = '{32'h78700000, 32'h78700000, 1'b1, 2'd0, 3'd2, 3'd2};
    vecs[1] = '{32'h7F800000, 32'h7FC00001, 1'b0, 2'd1, 3'd3, 3'd4};
    vecs[2] = '{32'h00000001, 32'h7F800001, 1'b0, 2'd2, 3'd1, 3'd5};
    vecs[3] = '{32'h80000000, 32'hFF800000, 1'b1, 2'd3, 3'd0, 3'd3};
    vecs[4] = '{32'h3F800000, 32'hC0490FDB, 1'b0, 2'd0, 3'd2, 3'd2};
    vecs[5] = '{32'h807FFFFF, 32'h7FFFFFFF, 1'b1, 2'd1, 3'd1, 3'd4};
    vecs[6] = '{32'h00800000, 32'h7FBFFFFF, 1'b0, 2'd2, 3'd2, 3'd5};

    // Reset state, before any clock edge.
    #2;
    chk_obs("reset_obs", obs, 74'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_fill", 32'(fill), 32'd0);
    chk("reset_cnt", 32'(issued_cnt), 32'd0);
    tick();
    rst = 1'b1;
    chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);

    // Single ops, one-cycle latency, hold when empty.
    for (int i = 0; i < 7; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_sub = vecs[i].sub; in_rm = vecs[i].rm;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk_obs($sformatf("vec%0d_issue", i), obs, exp_obs(1'b1, vecs[i]));
      chk_obs($sformatf("vec%0d_issue_w4", i), obs4, exp_obs(1'b1, vecs[i]));
      chk($sformatf("vec%0d_fill", i), 32'(fill), 32'd1);
      tick();
      chk_obs($sformatf("vec%0d_hold", i), obs, exp_obs(1'b0, vecs[i]));
      chk($sformatf("vec%0d_fill_empty", i), 32'(fill), 32'd0);
    end
    chk("cnt_after_vecs", 32'(issued_cnt), 32'd7);

    // Backpressure: queue fills at 2, third op waits upstream.
    pipe_stall = 1'b1;
    in_valid = 1'b1;
    in_b = 32'h3F800000; in_sub = 1'b0; in_rm = 2'd0;
    in_a = {1'b0, 8'd10, 23'd0};
    tick();
    chk("bp_fill1", 32'(fill), 32'd1);
    chk("bp_ex_p0", 32'(Ex), 32'd10);
    in_a = {1'b0, 8'd11, 23'd1};
    tick();
    chk("bp_fill2", 32'(fill), 32'd2);
    chk("bp_in_ready0", 32'(in_ready), 32'd0);
    chk("bp_in_ready0_w4", 32'(in_ready4), 32'd0);
    chk("bp_enable0", 32'(enable), 32'd0);
    in_a = {1'b0, 8'd12, 23'd2};
    tick();
    chk("bp_fill_held", 32'(fill4), 32'd2);
    chk("bp_ex_stable", 32'(Ex), 32'd10);
    chk("bp_mx_stable", 32'(Mx), 32'd0);
    pipe_stall = 1'b0;
    #1;
    chk("bp_enable1", 32'(enable), 32'd1);
    chk("bp_enable1_w4", 32'(enable4), 32'd1);
    tick();
    chk("bp_ex_p1", 32'(Ex), 32'd11);
    chk("bp_fill_after_pop", 32'(fill), 32'd1);
    chk("bp_in_ready1", 32'(in_ready), 32'd1);
    tick();
    chk("bp_ex_p2", 32'(Ex), 32'd12);
    chk("bp_mx_p2", 32'(Mx), 32'd2);
    in_valid = 1'b0;
    tick();
    chk("bp_drained_valid", 32'(out_valid), 32'd0);
    chk("bp_cnt", 32'(issued_cnt), 32'd10);

    // Streaming from a fresh reset; 17 pops wraps the 4-bit counter to 1.
    do_reset();
    in_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      in_a = {1'b0, 8'(k), 23'(k)};
      tick();
      chk($sformatf("stream%0d_ex", k), 32'(Ex), 32'(k));
      chk($sformatf("stream%0d_fill", k), 32'(fill), 32'd1);
      if (k == 18) begin
        chk("wrap_cnt4", 32'(issued_cnt4), 32'd1);
        chk("stream_cnt17", 32'(issued_cnt), 32'd17);
      end
    end
    chk("stream_cnt19", 32'(issued_cnt), 32'd19);
    in_valid = 1'b0;
    tick();
    chk("stream_cnt20", 32'(issued_cnt), 32'd20);
    chk("stream_cnt4_20", 32'(issued_cnt4), 32'd4);

    // Asynchronous reset with a full queue.
    pipe_stall = 1'b1;
    in_valid = 1'b1;
    in_a = 32'h40400000;
    tick();
    in_a = 32'h40800000;
    tick();
    in_valid = 1'b0;
    chk("rst_mid_fill_before", 32'(fill), 32'd2);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_fill", 32'(fill), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mid_ex", 32'(Ex), 32'd0);
    chk("rst_mid_cnt", 32'(issued_cnt), 32'd0);
    tick();
    rst = 1'b1;
    pipe_stall = 1'b0;
    tick();
    chk("rst_post_in_ready", 32'(in_ready), 32'd1);
    in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b1; in_rm = 2'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_obs("rst_post_issue", obs,
            exp_obs(1'b1, '{32'h3F800000, 32'h40000000, 1'b1, 2'd3, 3'd2, 3'd2}));
    tick();
    chk("rst_post_cnt", 32'(issued_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
